// File: rtl/pio_poll_pkg.sv
// Shared types and configuration helpers for the PIO polling master.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    CAPTURE
  } state_t;

  // Wide enough to hold the largest supported read latency (4).
  localparam int LAT_CNT_W = 3;

  function automatic bit poll_div_ok(input int poll_div, input int read_latency, input int width);
    return (poll_div >= read_latency + 4) && (read_latency >= 1) && (read_latency <= 4) &&
           (width >= 1) && (width <= 32);
  endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// Free-running poll interval timer: one-cycle expiry every POLL_DIV enabled cycles.
// Combinational expiry in the cycle the count reaches zero; held at reload while disabled.
module pio_poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic expiry
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (!enable || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expiry = enable && (cnt == '0);

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator polling a PIO data register into value plus rise/fall/change strobes.
// Capture visible READ_LATENCY+2 cycles after command acceptance; waits indefinitely on waitrequest.
module pio_poll_master #(
  parameter int WIDTH        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int BASE_ADDR    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             poll_now,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change_pulse,
  output logic             busy
);

  import pio_poll_pkg::*;

  if (!poll_div_ok(POLL_DIV, READ_LATENCY, WIDTH)) begin : g_bad_cfg
    $error("pio_poll_master: illegal WIDTH/POLL_DIV/READ_LATENCY combination");
  end

  state_t               state;
  state_t               state_nx;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 pending;
  logic                 expiry;
  logic                 poll_req;
  logic                 accept;
  logic                 last_wait;
  logic [WIDTH-1:0]     sample;
  logic                 unused_readdata;

  pio_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .expiry (expiry)
  );

  assign poll_req    = expiry | poll_now | pending;
  assign accept      = (state == REQ) && !avm_waitrequest;
  assign last_wait   = (state == WAIT_DATA) && (lat_cnt == LAT_CNT_W'(1));
  assign avm_address = 2'(BASE_ADDR);
  assign avm_read    = (state == REQ);
  assign busy        = (state == REQ) || (state == WAIT_DATA);
  // Bits above WIDTH-1 are deliberately ignored.
  assign unused_readdata = ^avm_readdata;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (poll_req) state_nx = REQ;
      REQ:       if (!avm_waitrequest) state_nx = WAIT_DATA;
      WAIT_DATA: if (lat_cnt == LAT_CNT_W'(1)) state_nx = CAPTURE;
      CAPTURE:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
      pending <= 1'b0;
      sample  <= '0;
    end else begin
      if (accept) begin
        lat_cnt <= LAT_CNT_W'(READ_LATENCY);
      end else if (state == WAIT_DATA) begin
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
      end
      // Requests arriving mid-transaction collapse into a single follow-up poll.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (expiry || poll_now) begin
        pending <= 1'b1;
      end
      if (last_wait) begin
        sample <= avm_readdata[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value        <= '0;
      value_valid  <= 1'b0;
      rise         <= '0;
      fall         <= '0;
      change_pulse <= 1'b0;
    end else begin
      rise         <= '0;
      fall         <= '0;
      change_pulse <= 1'b0;
      if (state == CAPTURE) begin
        value <= sample;
        // The first capture has no previous value to compare against.
        if (!value_valid) begin
          value_valid <= 1'b1;
        end else begin
          rise         <= sample & ~value;
          fall         <= ~sample & value;
          change_pulse <= |(sample ^ value);
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_poll_master.sv
// Randomised and directed bench for pio_poll_master against a timeline-based reference model.
module tb_pio_poll_master;

  localparam int W  = 2;
  localparam int PD = 8;
  localparam int RL = 2;
  localparam int BA = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          poll_now;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [31:0]   avm_readdata;
  logic [W-1:0]  value;
  logic          value_valid;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic          change_pulse;
  logic          busy;

  pio_poll_master #(
    .WIDTH(W), .POLL_DIV(PD), .READ_LATENCY(RL), .BASE_ADDR(BA)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .poll_now(poll_now),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .value(value), .value_valid(value_valid),
    .rise(rise), .fall(fall), .change_pulse(change_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs applied at the start of the next cycle by tick().
  logic        nx_rst, nx_en, nx_poll, nx_wr;
  logic [31:0] nx_rd;

  // Reference model: absolute cycle timeline of the current transaction.
  int          mc = 0;
  int          m_idx, m_free_at, m_acc, m_samp_cyc, m_cap_due;
  bit          m_in_req, m_pend, m_vv, m_chg;
  logic [W-1:0] m_val, m_samp, m_rise, m_fall;
  int          rd_cycles = 0;
  int          acc_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, mc);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_free_at = 0; m_acc = -100; m_samp_cyc = -1; m_cap_due = -1;
    m_in_req = 0; m_pend = 0; m_vv = 0; m_chg = 0;
    m_val = '0; m_samp = '0; m_rise = '0; m_fall = '0;
  endtask

  task automatic model_step();
    bit expiry, idle, req, exp_busy;
    if (!reset_n) begin
      model_reset();
      check("rst_read", avm_read, 0);
      check("rst_value", value, 0);
      check("rst_valid", value_valid, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_change", change_pulse, 0);
      check("rst_busy", busy, 0);
    end else begin
      if (mc == m_cap_due) begin
        if (!m_vv) begin
          m_vv = 1; m_rise = '0; m_fall = '0; m_chg = 0;
        end else begin
          m_rise = m_samp & ~m_val;
          m_fall = ~m_samp & m_val;
          m_chg  = |(m_samp ^ m_val);
        end
        m_val = m_samp;
      end else begin
        m_rise = '0; m_fall = '0; m_chg = 0;
      end
      if (mc == m_samp_cyc) m_samp = avm_readdata[W-1:0];
      exp_busy = m_in_req || (mc > m_acc && mc <= m_acc + RL);
      check("read", avm_read, m_in_req);
      check("address", avm_address, BA);
      check("busy", busy, exp_busy);
      check("value", value, m_val);
      check("valid", value_valid, m_vv);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("change", change_pulse, m_chg);
      rd_cycles += avm_read ? 1 : 0;
      acc_cnt   += (avm_read && !avm_waitrequest) ? 1 : 0;
      expiry = enable && (m_idx % PD == PD - 1);
      idle   = !m_in_req && (mc >= m_free_at);
      req    = expiry || poll_now || m_pend;
      if (m_in_req && !avm_waitrequest) begin
        m_in_req   = 0;
        m_acc      = mc;
        m_samp_cyc = mc + RL;
        m_cap_due  = mc + RL + 2;
        m_free_at  = mc + RL + 2;
      end
      if (idle) begin
        if (req) begin m_in_req = 1; m_pend = 0; end
      end else if (expiry || poll_now) begin
        m_pend = 1;
      end
      m_idx = enable ? m_idx + 1 : 0;
    end
    mc++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    reset_n = nx_rst; enable = nx_en; poll_now = nx_poll; nx_poll = 0;
    avm_waitrequest = nx_wr; avm_readdata = nx_rd;
    @(negedge clk);
    model_step();
  endtask

  // Returns in the cycle where the capture of the next transaction is visible.
  task automatic wait_result();
    int n = 0;
    while (!busy && n < 60) begin tick(); n++; end
    while (busy && n < 60) begin tick(); n++; end
    tick();
    check("wait_timeout", n >= 60, 0);
  endtask

  initial begin
    int n, r0, a0;
    model_reset();
    reset_n = 0; enable = 0; poll_now = 0; avm_waitrequest = 0; avm_readdata = '0;
    nx_rst = 0; nx_en = 0; nx_poll = 0; nx_wr = 0; nx_rd = '0;
    repeat (3) tick();
    nx_rst = 1; tick();
    check("init_value", value, 0);
    check("init_valid", value_valid, 0);
    check("init_read", avm_read, 0);

    // First automatic poll and first capture
    nx_rd = 32'h2; nx_en = 1; tick();
    n = 0;
    while (!avm_read && n < 40) begin tick(); n++; end
    check("first_poll_delay", n, PD);
    wait_result();
    check("t1_value", value, 2'b10);
    check("t1_valid", value_valid, 1);
    check("t1_change", change_pulse, 0);
    check("t1_rise", rise, 0);
    check("t1_fall", fall, 0);
    nx_en = 0;

    // Edge strobes
    nx_rd = 32'h1; nx_poll = 1; tick(); wait_result();
    check("t2_rise", rise, 2'b01);
    check("t2_fall", fall, 2'b10);
    check("t2_change", change_pulse, 1);
    tick();
    check("t2_change_one_cycle", change_pulse, 0);
    nx_poll = 1; tick(); wait_result();
    check("t3_same_change", change_pulse, 0);
    check("t3_same_rise", rise, 0);

    // Upper readdata bits ignored
    nx_rd = 32'hFFFF_FFFC; nx_poll = 1; tick(); wait_result();
    check("upper_value", value, 2'b00);
    check("upper_fall", fall, 2'b01);

    // Waitrequest held for 5 cycles
    nx_rd = 32'h2; nx_wr = 1; r0 = rd_cycles; nx_poll = 1; tick();
    repeat (5) tick();
    nx_wr = 0; tick();
    repeat (RL) tick();
    tick();
    check("wr_early_change", change_pulse, 0);
    check("wr_read_cycles", rd_cycles - r0, 6);
    tick();
    check("wr_value", value, 2'b10);
    check("wr_change", change_pulse, 1);

    // Multiple requests during one transaction -> one extra read
    a0 = acc_cnt; nx_wr = 1; nx_poll = 1; tick();
    tick(); nx_poll = 1; tick(); tick(); nx_poll = 1; tick(); nx_poll = 1; tick();
    nx_wr = 0; repeat (30) tick();
    check("pending_reads", acc_cnt - a0, 2);

    // Reset in WAIT_DATA
    nx_rd = 32'h3; nx_poll = 1; tick(); tick(); tick();
    check("in_wait", {busy, avm_read}, 2'b10);
    reset_n = 0; nx_rst = 0; #1;
    check("async_value", value, 0);
    check("async_valid", value_valid, 0);
    check("async_busy", busy, 0);
    tick(); tick(); nx_rst = 1; tick();
    nx_rd = 32'h1; nx_poll = 1; tick(); wait_result();
    check("post_rst_value", value, 2'b01);
    check("post_rst_valid", value_valid, 1);
    check("post_rst_change", change_pulse, 0);
    check("post_rst_rise", rise, 0);

    // Reset while stuck in REQ drops avm_read immediately
    nx_wr = 1; nx_poll = 1; tick(); repeat (3) tick();
    check("stuck_read", avm_read, 1);
    reset_n = 0; nx_rst = 0; #1;
    check("async_read", avm_read, 0);
    tick(); tick(); nx_rst = 1; nx_wr = 0; tick();

    // Randomised traffic
    nx_en = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(39) == 0) nx_en = !nx_en;
      nx_poll = ($urandom_range(9) == 0);
      nx_wr   = ($urandom_range(2) == 0);
      nx_rd   = $urandom;
      nx_rst  = ($urandom_range(399) != 0);
      tick();
    end
    nx_rst = 1; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
